// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle phase sequencer.
// Holds the FSM state encoding, write-back select codes and target-alignment helpers.
package mc_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   localparam int IALIGN_WORD = 4;
   localparam int IALIGN_HALF = 2;

   function automatic logic ialign_legal(input int ialign);
      return (ialign == IALIGN_WORD) || (ialign == IALIGN_HALF);
   endfunction

   // Low PC bits that must be zero for a legal control-transfer target.
   function automatic logic [1:0] align_mask(input int ialign);
      return (ialign == IALIGN_HALF) ? 2'b01 : 2'b11;
   endfunction

endpackage

// File: rtl/mc_next_pc.sv
// Combinational next-PC selection and misaligned-target detection.
// Any IALIGN other than 2 is treated as 4-byte alignment.
module mc_next_pc
   import mc_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int IALIGN = 4
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu_out,
   input  logic            branch,
   input  logic            jal,
   input  logic            jalr,
   input  logic            alu_zero,
   output logic [XLEN-1:0] npc,
   output logic            taken,
   output logic            misaligned
);

   localparam logic [1:0] AMASK = align_mask(IALIGN);

   logic br_taken;

   always_comb begin
      br_taken = branch & alu_zero;
      taken    = jal | jalr | br_taken;
      if (jalr) begin
         npc = alu_out & ~XLEN'(1);
      end else if (jal || br_taken) begin
         npc = pc + imm;
      end else begin
         npc = pc + XLEN'(4);
      end
      // Only a redirect can land misaligned; pc+4 is aligned by construction.
      misaligned = taken && ((npc[1:0] & AMASK) != 2'b00);
   end

endmodule

// File: rtl/mc_sequencer.sv
// Handshake-driven multi-cycle phase sequencer with PC, next-PC, trap and instret ownership.
//
//   state  | meaning
//   FETCH  | request instruction, wait for imem_ready, latch IR
//   DECODE | latch operand registers
//   EXEC   | latch ALU-out and next PC, check target alignment
//   MEM    | data access, wait for dmem_ready; stores retire here
//   WB     | register write-back, retire
//   TRAP   | misaligned target seen; absorbing until rst
module mc_sequencer
   import mc_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              IALIGN   = 4,
   parameter int              CNT_W    = 64
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             ir_we,
   output logic             opnd_we,
   output logic             alu_we,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             reg_write,
   input  logic             branch,
   input  logic             jal,
   input  logic             jalr,
   input  logic             alu_zero,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  alu_out,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic [XLEN-1:0]  pc,
   output logic             trap,
   output logic [XLEN-1:0]  trap_pc,
   output logic [CNT_W-1:0] instret
);

   state_t           state_q, state_d;
   logic [XLEN-1:0]  pc_q, npc_q, trap_pc_q;
   logic [CNT_W-1:0] instret_q;
   logic [1:0]       wb_sel_q, wb_sel_d;
   logic [XLEN-1:0]  npc_c;
   logic             taken_c, misaligned_c;
   logic             retire;

   mc_next_pc #(
      .XLEN   (XLEN),
      .IALIGN (IALIGN)
   ) u_next_pc (
      .pc         (pc_q),
      .imm        (imm),
      .alu_out    (alu_out),
      .branch     (branch),
      .jal        (jal),
      .jalr       (jalr),
      .alu_zero   (alu_zero),
      .npc        (npc_c),
      .taken      (taken_c),
      .misaligned (misaligned_c)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH:  if (imem_ready) state_d = DECODE;
         DECODE: state_d = EXEC;
         EXEC: begin
            if (misaligned_c)             state_d = TRAP;
            else if (is_load || is_store) state_d = MEM;
            else                          state_d = WB;
         end
         MEM: begin
            if (dmem_ready) state_d = is_store ? FETCH : WB;
         end
         WB:      state_d = FETCH;
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   // Strobes are gated by rst so an access aborted by reset never issues a partial write.
   always_comb begin
      imem_req = !rst && (state_q == FETCH);
      ir_we    = imem_req && imem_ready;
      opnd_we  = !rst && (state_q == DECODE);
      alu_we   = !rst && (state_q == EXEC);
      dmem_req = !rst && (state_q == MEM);
      dmem_we  = dmem_req && is_store;
      rf_we    = !rst && (state_q == WB) && reg_write;
   end

   always_comb begin
      wb_sel_d = WB_ALU;
      if (jal || jalr)  wb_sel_d = WB_PC;
      else if (is_load) wb_sel_d = WB_MEM;
      retire = ((state_q == MEM) && dmem_ready && is_store) || (state_q == WB);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         npc_q     <= RESET_PC;
         trap_pc_q <= '0;
         instret_q <= '0;
         wb_sel_q  <= WB_ALU;
      end else begin
         state_q <= state_d;
         if (state_q == EXEC) begin
            npc_q    <= npc_c;
            wb_sel_q <= wb_sel_d;
            if (misaligned_c) trap_pc_q <= pc_q;
         end
         if (retire) begin
            pc_q      <= npc_q;
            instret_q <= instret_q + CNT_W'(1);
         end
      end
   end

   assign pc      = pc_q;
   assign trap    = (state_q == TRAP);
   assign trap_pc = trap_pc_q;
   assign instret = instret_q;
   assign wb_sel  = wb_sel_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: one word-aligned instance (RESET_PC=0x1000) and
// one half-word-aligned instance (RESET_PC=0) share stimulus.
module tb_mc_sequencer;

   localparam int XLEN  = 64;
   localparam int CNT_W = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             imem_ready, dmem_ready;
   logic             is_load, is_store, reg_write, branch, jal, jalr, alu_zero;
   logic [XLEN-1:0]  imm, alu_out;

   logic             imem_req, ir_we, opnd_we, alu_we, dmem_req, dmem_we, rf_we, trap;
   logic [1:0]       wb_sel;
   logic [XLEN-1:0]  pc, trap_pc;
   logic [CNT_W-1:0] instret;

   logic             imem_req_h, ir_we_h, opnd_we_h, alu_we_h, dmem_req_h, dmem_we_h, rf_we_h, trap_h;
   logic [1:0]       wb_sel_h;
   logic [XLEN-1:0]  pc_h, trap_pc_h;
   logic [CNT_W-1:0] instret_h;

   int total = 0;
   int bad   = 0;

   mc_sequencer #(.XLEN(XLEN), .RESET_PC(64'h1000), .IALIGN(4), .CNT_W(CNT_W)) dut4 (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we), .opnd_we(opnd_we), .alu_we(alu_we),
      .is_load(is_load), .is_store(is_store), .reg_write(reg_write), .branch(branch),
      .jal(jal), .jalr(jalr), .alu_zero(alu_zero), .imm(imm), .alu_out(alu_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc), .trap(trap), .trap_pc(trap_pc), .instret(instret)
   );

   mc_sequencer #(.XLEN(XLEN), .RESET_PC(64'h0), .IALIGN(2), .CNT_W(CNT_W)) dut2 (
      .clk(clk), .rst(rst),
      .imem_req(imem_req_h), .imem_ready(imem_ready), .ir_we(ir_we_h), .opnd_we(opnd_we_h), .alu_we(alu_we_h),
      .is_load(is_load), .is_store(is_store), .reg_write(reg_write), .branch(branch),
      .jal(jal), .jalr(jalr), .alu_zero(alu_zero), .imm(imm), .alu_out(alu_out),
      .dmem_req(dmem_req_h), .dmem_we(dmem_we_h), .dmem_ready(dmem_ready),
      .rf_we(rf_we_h), .wb_sel(wb_sel_h), .pc(pc_h), .trap(trap_h), .trap_pc(trap_pc_h), .instret(instret_h)
   );

   // {imem_req, ir_we, opnd_we, alu_we, dmem_req, dmem_we, rf_we} of the word-aligned instance
   function automatic logic [6:0] strobes();
      return {imem_req, ir_we, opnd_we, alu_we, dmem_req, dmem_we, rf_we};
   endfunction

   task automatic set_decode(input logic ld, st, rw, br, j, jr, z,
                             input logic [XLEN-1:0] im, ao);
      is_load = ld; is_store = st; reg_write = rw; branch = br;
      jal = j; jalr = jr; alu_zero = z; imm = im; alu_out = ao;
   endtask

   // Zero-wait instruction, then one idle FETCH cycle so the retired pc is visible.
   task automatic run_instr(input logic ld, st, rw, br, j, jr, z,
                            input logic [XLEN-1:0] im, ao,
                            output logic rf_seen, output logic [1:0] wb_last);
      int n;
      set_decode(ld, st, rw, br, j, jr, z, im, ao);
      n = (ld && !st) ? 5 : 4;
      rf_seen = 1'b0;
      wb_last = 2'd0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         imem_ready = (i == 0);
         dmem_ready = 1'b1;
         #1;
         rf_seen = rf_seen | rf_we;
         wb_last = wb_sel;
      end
      @(posedge clk); #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
      set_decode(0, 0, 0, 0, 0, 0, 0, '0, '0);
      repeat (2) @(posedge clk);
      #2;
      total++; if (pc !== 64'h1000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 64'h1000); end
      total++; if (pc_h !== 64'h0) begin bad++; $display("FAIL reset_pc_h2 got=%h exp=%h", pc_h, 64'h0); end
      total++; if (instret !== '0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret); end
      total++; if (trap !== 1'b0 || trap_pc !== '0) begin bad++; $display("FAIL reset_trap got=%b/%h exp=0/0", trap, trap_pc); end
      total++; if (strobes() !== 7'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=%b", strobes(), 7'b0); end
      rst = 1'b0;
      #1;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_imem_req got=%b exp=1", imem_req); end
   endtask

   task automatic test_alu();
      logic [6:0] exp_s [0:3];
      exp_s = '{7'b1100000, 7'b0010000, 7'b0001000, 7'b0000001};
      set_decode(0, 0, 1, 0, 0, 0, 0, 64'h0, 64'h5);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         imem_ready = (i == 0);
         #1;
         total++; if (strobes() !== exp_s[i]) begin bad++; $display("FAIL alu_strobes[%0d] got=%b exp=%b", i, strobes(), exp_s[i]); end
         if (i == 3) begin
            total++; if (wb_sel !== 2'd0) begin bad++; $display("FAIL alu_wb_sel got=%0d exp=0", wb_sel); end
         end
      end
      @(posedge clk); #2;
      total++; if (pc !== 64'h1004) begin bad++; $display("FAIL alu_pc got=%h exp=%h", pc, 64'h1004); end
      total++; if (pc_h !== 64'h4) begin bad++; $display("FAIL alu_pc_h2 got=%h exp=%h", pc_h, 64'h4); end
      total++; if (instret !== 64'd1) begin bad++; $display("FAIL alu_instret got=%0d exp=1", instret); end
   endtask

   task automatic test_load_wait();
      logic [6:0] exp_s [0:9];
      logic       ir_r  [0:9];
      logic       dm_r  [0:9];
      exp_s = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1100000, 7'b0010000,
                7'b0001000, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000001};
      ir_r  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      dm_r  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      set_decode(1, 0, 1, 0, 0, 0, 0, 64'h0, 64'h40);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         imem_ready = ir_r[i];
         dmem_ready = dm_r[i];
         #1;
         total++; if (strobes() !== exp_s[i]) begin bad++; $display("FAIL load_strobes[%0d] got=%b exp=%b", i, strobes(), exp_s[i]); end
         if (i < 4) begin
            total++; if (pc !== 64'h1004) begin bad++; $display("FAIL load_pc_stable[%0d] got=%h exp=%h", i, pc, 64'h1004); end
         end
         if (i == 9) begin
            total++; if (wb_sel !== 2'd1) begin bad++; $display("FAIL load_wb_sel got=%0d exp=1", wb_sel); end
         end
      end
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      #1;
      total++; if (pc !== 64'h1008) begin bad++; $display("FAIL load_pc got=%h exp=%h", pc, 64'h1008); end
      total++; if (instret !== 64'd2) begin bad++; $display("FAIL load_instret got=%0d exp=2", instret); end
   endtask

   task automatic test_store();
      logic [6:0] exp_s [0:3];
      exp_s = '{7'b1100000, 7'b0010000, 7'b0001000, 7'b0000110};
      set_decode(0, 1, 0, 0, 0, 0, 0, 64'h0, 64'h80);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         imem_ready = (i == 0);
         dmem_ready = 1'b1;
         #1;
         total++; if (strobes() !== exp_s[i]) begin bad++; $display("FAIL store_strobes[%0d] got=%b exp=%b", i, strobes(), exp_s[i]); end
      end
      @(posedge clk); #2;
      total++; if (pc !== 64'h100c) begin bad++; $display("FAIL store_pc got=%h exp=%h", pc, 64'h100c); end
      total++; if (instret !== 64'd3) begin bad++; $display("FAIL store_instret got=%0d exp=3", instret); end

      // Same store, reset lands while MEM is waiting.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         imem_ready = (i == 0);
         dmem_ready = 1'b0;
         #1;
      end
      @(posedge clk); #1;
      #1;
      total++; if (dmem_we !== 1'b1) begin bad++; $display("FAIL store_mem_wait_we got=%b exp=1", dmem_we); end
      rst = 1'b1;
      #1;
      total++; if (strobes() !== 7'b0) begin bad++; $display("FAIL store_rst_strobes got=%b exp=%b", strobes(), 7'b0); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      total++; if (pc !== 64'h1000) begin bad++; $display("FAIL store_rst_pc got=%h exp=%h", pc, 64'h1000); end
      total++; if (instret !== 64'd0) begin bad++; $display("FAIL store_rst_instret got=%0d exp=0", instret); end
   endtask

   task automatic test_jalr();
      logic rf_seen;
      logic [1:0] wb_last;
      run_instr(0, 0, 1, 0, 0, 1, 0, 64'h0, 64'h101, rf_seen, wb_last);
      total++; if (pc !== 64'h100) begin bad++; $display("FAIL jalr_pc got=%h exp=%h", pc, 64'h100); end
      total++; if (pc_h !== 64'h100) begin bad++; $display("FAIL jalr_pc_h2 got=%h exp=%h", pc_h, 64'h100); end
      total++; if (wb_last !== 2'd2) begin bad++; $display("FAIL jalr_wb_sel got=%0d exp=2", wb_last); end
      total++; if (rf_seen !== 1'b1) begin bad++; $display("FAIL jalr_rf_we got=%b exp=1", rf_seen); end
   endtask

   task automatic test_branch();
      logic rf_seen;
      logic [1:0] wb_last;
      run_instr(0, 0, 1, 0, 0, 1, 0, 64'h0, 64'h11, rf_seen, wb_last);
      total++; if (pc !== 64'h10) begin bad++; $display("FAIL branch_setup_pc got=%h exp=%h", pc, 64'h10); end
      run_instr(0, 0, 0, 1, 0, 0, 1, 64'hffff_ffff_ffff_fff8, 64'h0, rf_seen, wb_last);
      total++; if (pc !== 64'h8) begin bad++; $display("FAIL branch_taken_pc got=%h exp=%h", pc, 64'h8); end
      total++; if (rf_seen !== 1'b0) begin bad++; $display("FAIL branch_rf_we got=%b exp=0", rf_seen); end
      run_instr(0, 0, 1, 0, 0, 1, 0, 64'h0, 64'h10, rf_seen, wb_last);
      run_instr(0, 0, 0, 1, 0, 0, 0, 64'hffff_ffff_ffff_fff8, 64'h0, rf_seen, wb_last);
      total++; if (pc !== 64'h14) begin bad++; $display("FAIL branch_not_taken_pc got=%h exp=%h", pc, 64'h14); end
   endtask

   task automatic test_misaligned_jal();
      logic rf_seen;
      logic [1:0] wb_last;
      run_instr(0, 0, 1, 0, 0, 1, 0, 64'h0, 64'h20, rf_seen, wb_last);
      total++; if (pc !== 64'h20) begin bad++; $display("FAIL jal_setup_pc got=%h exp=%h", pc, 64'h20); end
      run_instr(0, 0, 1, 0, 1, 0, 0, 64'h2, 64'h0, rf_seen, wb_last);
      total++; if (trap !== 1'b1) begin bad++; $display("FAIL jal_trap got=%b exp=1", trap); end
      total++; if (trap_pc !== 64'h20) begin bad++; $display("FAIL jal_trap_pc got=%h exp=%h", trap_pc, 64'h20); end
      total++; if (rf_seen !== 1'b0) begin bad++; $display("FAIL jal_trap_rf_we got=%b exp=0", rf_seen); end
      total++; if (instret !== 64'd6) begin bad++; $display("FAIL jal_trap_instret got=%0d exp=6", instret); end
      total++; if (pc_h !== 64'h22) begin bad++; $display("FAIL jal_h2_pc got=%h exp=%h", pc_h, 64'h22); end
      total++; if (trap_h !== 1'b0) begin bad++; $display("FAIL jal_h2_trap got=%b exp=0", trap_h); end
      total++; if (instret_h !== 64'd7) begin bad++; $display("FAIL jal_h2_instret got=%0d exp=7", instret_h); end
      imem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      total++; if (trap !== 1'b1 || pc !== 64'h20) begin bad++; $display("FAIL trap_hold got=%b/%h exp=1/%h", trap, pc, 64'h20); end
      total++; if (strobes() !== 7'b0) begin bad++; $display("FAIL trap_strobes got=%b exp=%b", strobes(), 7'b0); end
      imem_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_wait();
      test_store();
      test_jalr();
      test_branch();
      test_misaligned_jal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Parametrised multi-cycle phase sequencer and PC unit for the RV64 core top.
- Replaces the fixed free-running 0..4 phase counter with a handshake-driven FSM. Fetch and data-memory phases stall on ready signals; non-memory instructions skip the MEM phase.
- Owns the PC, next-PC selection, misaligned-target trap detection and a retired-instruction counter.
- Sits between the control decoder, the datapath latches (IR, operand, ALU-out registers), the register file and both memories.

Parameters:
- XLEN, 64, datapath/PC width
- RESET_PC, 0, PC value loaded on reset
- IALIGN, 4, required target alignment in bytes (4 or 2)
- CNT_W, 64, instret counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- ir_we  out  1  latch instruction register
- opnd_we  out  1  latch operand registers a/b
- alu_we  out  1  latch ALU-out register
- is_load  in  1  decoded load
- is_store  in  1  decoded store
- reg_write  in  1  decoded register write
- branch  in  1  decoded conditional branch
- jal  in  1  decoded jal
- jalr  in  1  decoded jalr
- alu_zero  in  1  ALU branch condition
- imm  in  XLEN  immediate
- alu_out  in  XLEN  combinational ALU result
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write
- dmem_ready  in  1  data access complete
- rf_we  out  1  register file write strobe
- wb_sel  out  2  0=ALU-out, 1=load data, 2=pc+4
- pc  out  XLEN  current PC (also fetch address)
- trap  out  1  sticky misaligned-target trap
- trap_pc  out  XLEN  PC of faulting instruction
- instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=FETCH, pc=RESET_PC, instret=0, trap=0, trap_pc=0.
  - Every strobe is forced 0 during any cycle rst is high, so an aborted access never issues a partial write.
- Strobe timing: strobes are Moore decodes of the registered state, except ir_we=imem_req&imem_ready.
- FETCH:
  - imem_req=1 and held until imem_ready; pc must stay stable while waiting.
  - On ready: ir_we=1 in the same cycle, then go to DECODE.
- DECODE: opnd_we=1 for one cycle, then EXEC.
- EXEC:
  - alu_we=1.
  - npc register latched by priority:
    - jalr: alu_out with bit0 cleared
    - jal, or branch&alu_zero: pc+imm (XLEN modulo wrap)
    - otherwise: pc+4
  - Misalignment check: npc[1:0]!=0 when IALIGN=4, or npc[0]!=0 when IALIGN=2, on a jal/jalr/taken branch → TRAP. No memory or register side effects occur for that instruction.
  - Else if is_load|is_store → MEM; else → WB.
- MEM:
  - dmem_req=1, dmem_we=is_store; held until dmem_ready.
  - On ready: a store retires (pc<=npc, instret++, → FETCH); a load → WB.
  - is_load&is_store both high is treated as a store.
- WB:
  - rf_we=reg_write for exactly one cycle.
  - wb_sel=2 if jal|jalr, 1 if is_load, else 0.
  - pc<=npc, instret++ (wraps at 2^CNT_W), → FETCH.
- wb_sel holds its value in all states (don't-care outside WB but stable).
- TRAP: trap=1, trap_pc=pc of the faulting instruction. Absorbing state; all strobes 0 until rst.
- Latency with zero-wait memories: ALU/branch/jump 4 cycles, load 5, store 4. Each memory wait cycle adds 1.
- Decoder inputs must be stable from DECODE through retirement (driven from the IR).

Decomposition:
- Package mc_pkg holds:
  - state enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}
  - WB_ALU/WB_MEM/WB_PC constants
  - IALIGN legality constants
- One natural sub-module, mc_next_pc: combinational next-PC mux plus misalignment check, parametrised by XLEN/IALIGN.

Test Plan:
- Reset: hold rst 2 cycles with RESET_PC=0x1000 → pc=0x1000, instret=0, trap=0, all strobes 0. First cycle after release: imem_req=1.
- ALU add, imem_ready tied 1 → strobes ir_we, opnd_we, alu_we, rf_we on consecutive cycles. pc 0x0→0x4 after 4 cycles, wb_sel=0, instret=1.
- imem_ready delayed 3 cycles, then a load with dmem_ready delayed 2 → imem_req high 4 cycles with pc constant. dmem_req high 3 cycles with dmem_we=0. rf_we with wb_sel=1. Total 10 cycles.
- Store, zero wait → dmem_we=1 for 1 cycle, no rf_we, pc+4 after 4 cycles. Repeat with rst asserted mid-MEM → dmem_we=0 that cycle, pc=RESET_PC.
- Branch at pc=0x10, imm=-8, alu_zero=1 → pc=0x8. With alu_zero=0 → pc=0x14. jalr with alu_out=0x101 → pc=0x100, wb_sel=2.
- jal at pc=0x20, imm=0x2 (target 0x22, IALIGN=4) → trap=1, trap_pc=0x20, no rf_we, state held. Same stimulus with IALIGN=2 → pc=0x22, no trap.
